// File: rtl/regbank_mp_pkg.sv
// Shared constants and types for the multi-port register bank.
// Optional write-to-read bypass is enabled by defining RS5_REGBANK_BYPASS_EN.
package regbank_mp_pkg;

  localparam int REGBANK_MAX_RD_PORTS = 4;
  localparam int REGBANK_MAX_WR_PORTS = 3;

  typedef logic [4:0] reg_addr_t;

endpackage

// File: rtl/regbank_mp_if.sv
// Decode/writeback-facing bus of the register bank.
// The master side is decode plus writeback; the slave side is the bank itself.
interface regbank_mp_if #(
  parameter int NUM_REGS     = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 2
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [NUM_RD_PORTS-1:0][ADDR_W-1:0]     rs_i;
  logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rdata_o;
  logic [NUM_RD_PORTS-1:0]                 rbusy_o;
  logic [NUM_WR_PORTS-1:0]                 we_i;
  logic [NUM_WR_PORTS-1:0][ADDR_W-1:0]     wa_i;
  logic [NUM_WR_PORTS-1:0][DATA_WIDTH-1:0] wdata_i;
  logic                                    rsv_i;
  logic [ADDR_W-1:0]                       rsv_addr_i;
  logic [NUM_REGS-1:0]                     busy_vec_o;

  modport master (
    output rs_i, we_i, wa_i, wdata_i, rsv_i, rsv_addr_i,
    input  rdata_o, rbusy_o, busy_vec_o
  );

  modport slave (
    input  rs_i, we_i, wa_i, wdata_i, rsv_i, rsv_addr_i,
    output rdata_o, rbusy_o, busy_vec_o
  );

endinterface

// File: rtl/regbank_mp_scoreboard.sv
// Pending-write scoreboard: one flop per register, set by reservations and
// cleared by writeback; a reservation in the same cycle as a write wins.
module regbank_scoreboard
  import regbank_mp_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int NUM_WR_PORTS = 2,
  parameter int ADDR_W       = $clog2(NUM_REGS)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                rsv,
  input  logic [ADDR_W-1:0]                   rsv_addr,
  input  logic [NUM_WR_PORTS-1:0]             we,
  input  logic [NUM_WR_PORTS-1:0][ADDR_W-1:0] wa,
  output logic [NUM_REGS-1:0]                 busy_vec
);

  logic [NUM_REGS-1:0] busy_next;

  always_comb begin
    busy_next = busy_vec;
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      if (we[p] && (wa[p] != '0)) begin
        busy_next[wa[p]] = 1'b0;
      end
    end
    // Applied after the clears so a new producer keeps the register pending.
    if (rsv && (rsv_addr != '0)) begin
      busy_next[rsv_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_next;
    end
  end

endmodule

// File: rtl/regbank_mp.sv
// Parametrised multi-port register bank with pending-write scoreboard.
// Define RS5_REGBANK_BYPASS_EN to forward same-cycle write data to the reads.
module regbank_mp
  import regbank_mp_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 2
) (
  input  logic        clk,
  input  logic        reset,
  regbank_mp_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  if ((NUM_RD_PORTS < 1) || (NUM_RD_PORTS > REGBANK_MAX_RD_PORTS) ||
      (NUM_WR_PORTS < 1) || (NUM_WR_PORTS > REGBANK_MAX_WR_PORTS) ||
      ((NUM_REGS != 16) && (NUM_REGS != 32))) begin : g_bad_cfg
    $error("regbank_mp: illegal register or port configuration");
  end

  logic [DATA_WIDTH-1:0] regfile [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_vec;

  // Ports are visited in ascending order, so the highest-index writer lands last.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regfile[i] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
        if (bus.we_i[p] && (bus.wa_i[p] != '0)) begin
          regfile[bus.wa_i[p]] <= bus.wdata_i[p];
        end
      end
    end
  end

  regbank_scoreboard #(
    .NUM_REGS     (NUM_REGS),
    .NUM_WR_PORTS (NUM_WR_PORTS),
    .ADDR_W       (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .rsv      (bus.rsv_i),
    .rsv_addr (bus.rsv_addr_i),
    .we       (bus.we_i),
    .wa       (bus.wa_i),
    .busy_vec (busy_vec)
  );

  always_comb begin
    for (int r = 0; r < NUM_RD_PORTS; r++) begin
      bus.rdata_o[r] = regfile[bus.rs_i[r]];
      bus.rbusy_o[r] = busy_vec[bus.rs_i[r]];
`ifdef RS5_REGBANK_BYPASS_EN
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
        if (bus.we_i[p] && (bus.wa_i[p] == bus.rs_i[r])) begin
          bus.rdata_o[r] = bus.wdata_i[p];
          bus.rbusy_o[r] = 1'b0;
        end
      end
`endif
      // x0 is hardwired, and nothing stale may leak out while reset is held.
      if (reset || (bus.rs_i[r] == '0)) begin
        bus.rdata_o[r] = '0;
        bus.rbusy_o[r] = 1'b0;
      end
    end
  end

  assign bus.busy_vec_o = reset ? '0 : busy_vec;

endmodule

// File: tb/tb_regbank_mp.sv
// Directed scoreboard bench for regbank_mp: a default 32x2R2W bank plus a
// 16-register, 3-read-port bank; expectations follow RS5_REGBANK_BYPASS_EN.
module tb_regbank_mp;

`ifdef RS5_REGBANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  regbank_mp_if #(.NUM_REGS(32), .DATA_WIDTH(32), .NUM_RD_PORTS(2), .NUM_WR_PORTS(2)) bus_a ();
  regbank_mp_if #(.NUM_REGS(16), .DATA_WIDTH(32), .NUM_RD_PORTS(3), .NUM_WR_PORTS(2)) bus_b ();

  regbank_mp #(.NUM_REGS(32), .DATA_WIDTH(32), .NUM_RD_PORTS(2), .NUM_WR_PORTS(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  regbank_mp #(.NUM_REGS(16), .DATA_WIDTH(32), .NUM_RD_PORTS(3), .NUM_WR_PORTS(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus_a.we_i       = '0;
    bus_a.wa_i       = '0;
    bus_a.wdata_i    = '0;
    bus_a.rsv_i      = 1'b0;
    bus_a.rsv_addr_i = '0;
    bus_b.we_i       = '0;
    bus_b.wa_i       = '0;
    bus_b.wdata_i    = '0;
    bus_b.rsv_i      = 1'b0;
    bus_b.rsv_addr_i = '0;
  endtask

  task automatic apply_stimulus(input int port, input logic [4:0] addr, input logic [31:0] data);
    bus_a.we_i[port]    = 1'b1;
    bus_a.wa_i[port]    = addr;
    bus_a.wdata_i[port] = data;
  endtask

  task automatic reserve(input logic [4:0] addr);
    bus_a.rsv_i      = 1'b1;
    bus_a.rsv_addr_i = addr;
  endtask

  task automatic expect_value(input string tag, input logic [31:0] value);
    tag_q.push_back(tag);
    exp_q.push_back(value);
  endtask

  task automatic check_output(input logic [31:0] observed);
    string       tag;
    logic [31:0] expected;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("[TB] FAIL scoreboard_empty observed=%h expected=none", observed);
    end else begin
      tag      = tag_q.pop_front();
      expected = exp_q.pop_front();
      assert (observed === expected) else begin
        bad++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    bus_a.rs_i = '0;
    bus_b.rs_i = '0;
    tick();
    tick();

    bus_a.rs_i[0] = 5'd5;
    #1;
    expect_value("reset_rdata", 32'h0);        check_output(bus_a.rdata_o[0]);
    expect_value("reset_busy_vec", 32'h0);     check_output(bus_a.busy_vec_o);

    // Write x5, then pulse reset and confirm it is cleared.
    reset = 1'b0;
    apply_stimulus(0, 5'd5, 32'hDEADBEEF);
    tick();
    idle();
    #1;
    expect_value("x5_written", 32'hDEADBEEF); check_output(bus_a.rdata_o[0]);
    reset = 1'b1;
    tick();
    expect_value("x5_during_reset", 32'h0);   check_output(bus_a.rdata_o[0]);
    reset = 1'b0;
    #1;
    expect_value("x5_after_reset", 32'h0);    check_output(bus_a.rdata_o[0]);
    expect_value("busy_after_reset", 32'h0);  check_output(bus_a.busy_vec_o);

    // x0 ignores writes and reservations.
    apply_stimulus(0, 5'd0, 32'hFFFFFFFF);
    reserve(5'd0);
    bus_a.rs_i[0] = 5'd0;
    tick();
    idle();
    #1;
    expect_value("x0_rdata", 32'h0);          check_output(bus_a.rdata_o[0]);
    expect_value("x0_busy_vec", 32'h0);       check_output(bus_a.busy_vec_o);
    expect_value("x0_rbusy", 32'h0);          check_output(32'(bus_a.rbusy_o[0]));

    // Same-address write conflict: port 1 wins.
    apply_stimulus(0, 5'd7, 32'h11111111);
    apply_stimulus(1, 5'd7, 32'h22222222);
    bus_a.rs_i[1] = 5'd7;
    #1;
    expect_value("prio_same_cycle", BYPASS ? 32'h22222222 : 32'h0); check_output(bus_a.rdata_o[1]);
    tick();
    idle();
    bus_a.rs_i[0] = 5'd7;
    #1;
    expect_value("prio_rd0", 32'h22222222);   check_output(bus_a.rdata_o[0]);
    expect_value("prio_rd1", 32'h22222222);   check_output(bus_a.rdata_o[1]);

    // Two ports writing different registers together.
    apply_stimulus(0, 5'd8, 32'h00000088);
    apply_stimulus(1, 5'd9, 32'h00000099);
    tick();
    idle();
    bus_a.rs_i[0] = 5'd8;
    bus_a.rs_i[1] = 5'd9;
    #1;
    expect_value("dual_x8", 32'h00000088);    check_output(bus_a.rdata_o[0]);
    expect_value("dual_x9", 32'h00000099);    check_output(bus_a.rdata_o[1]);

    // Reserve x10, let it sit, then retire it through port 1.
    reserve(5'd10);
    tick();
    idle();
    tick();
    tick();
    tick();
    bus_a.rs_i[0] = 5'd10;
    #1;
    expect_value("x10_rbusy", 32'h1);               check_output(32'(bus_a.rbusy_o[0]));
    expect_value("x10_busy_vec", 32'd1 << 10);      check_output(bus_a.busy_vec_o);
    apply_stimulus(1, 5'd10, 32'h0000CAFE);
    bus_a.rs_i[1] = 5'd10;
    #1;
    expect_value("x10_wr_rbusy", BYPASS ? 32'h0 : 32'h1);        check_output(32'(bus_a.rbusy_o[1]));
    expect_value("x10_wr_rdata", BYPASS ? 32'h0000CAFE : 32'h0); check_output(bus_a.rdata_o[1]);
    expect_value("x10_wr_busy_vec", 32'd1 << 10);                check_output(bus_a.busy_vec_o);
    tick();
    idle();
    #1;
    expect_value("x10_cleared_rbusy", 32'h0);       check_output(32'(bus_a.rbusy_o[0]));
    expect_value("x10_cleared_busy_vec", 32'h0);    check_output(bus_a.busy_vec_o);
    expect_value("x10_data", 32'h0000CAFE);         check_output(bus_a.rdata_o[0]);

    // Reserve and write x12 in one cycle: data stored, bit stays set.
    reserve(5'd12);
    apply_stimulus(0, 5'd12, 32'h00000005);
    tick();
    idle();
    bus_a.rs_i[0] = 5'd12;
    #1;
    expect_value("x12_data", 32'h00000005);         check_output(bus_a.rdata_o[0]);
    expect_value("x12_busy_vec", 32'd1 << 12);      check_output(bus_a.busy_vec_o);
    expect_value("x12_rbusy", 32'h1);               check_output(32'(bus_a.rbusy_o[0]));
    reserve(5'd12);
    tick();
    idle();
    #1;
    expect_value("x12_rereserve", 32'd1 << 12);     check_output(bus_a.busy_vec_o);
    apply_stimulus(0, 5'd12, 32'h00000006);
    tick();
    idle();
    #1;
    expect_value("x12_single_clear", 32'h0);        check_output(bus_a.busy_vec_o);

    // Pending x3 overwritten in cycle N: bypass versus stored view.
    apply_stimulus(0, 5'd3, 32'h00001111);
    tick();
    idle();
    reserve(5'd3);
    tick();
    idle();
    #1;
    expect_value("x3_busy_vec", 32'd1 << 3);        check_output(bus_a.busy_vec_o);
    apply_stimulus(0, 5'd3, 32'h0000ABCD);
    bus_a.rs_i[0] = 5'd3;
    #1;
    expect_value("x3_cycle_n_rdata", BYPASS ? 32'h0000ABCD : 32'h00001111); check_output(bus_a.rdata_o[0]);
    expect_value("x3_cycle_n_rbusy", BYPASS ? 32'h0 : 32'h1);               check_output(32'(bus_a.rbusy_o[0]));
    tick();
    idle();
    #1;
    expect_value("x3_next_rdata", 32'h0000ABCD);    check_output(bus_a.rdata_o[0]);
    expect_value("x3_next_rbusy", 32'h0);           check_output(32'(bus_a.rbusy_o[0]));

    // A write addressed to x0 must never forward.
    apply_stimulus(1, 5'd0, 32'h00000077);
    bus_a.rs_i[0] = 5'd0;
    #1;
    expect_value("x0_no_bypass", 32'h0);            check_output(bus_a.rdata_o[0]);
    tick();
    idle();

    // 16-register, three-read-port bank.
    bus_b.we_i[0]    = 1'b1;
    bus_b.wa_i[0]    = 4'd15;
    bus_b.wdata_i[0] = 32'h00001234;
    tick();
    idle();
    for (int r = 0; r < 3; r++) begin
      bus_b.rs_i[r] = 4'd15;
    end
    #1;
    expect_value("b_x15_rd0", 32'h00001234);        check_output(bus_b.rdata_o[0]);
    expect_value("b_x15_rd1", 32'h00001234);        check_output(bus_b.rdata_o[1]);
    expect_value("b_x15_rd2", 32'h00001234);        check_output(bus_b.rdata_o[2]);
    expect_value("b_busy_vec", 32'h0);              check_output(32'(bus_b.busy_vec_o));

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regbank_mp.md
Name: regbank_mp

Overview:
- Parametrised multi-port integer register bank with per-register pending-write scoreboard and optional write-to-read bypass.
- Successor to the 2R1W bank: configurable depth (RV32I/RV32E), data width, read-port and write-port counts.
- Tracks registers reserved by long-latency units (mul/div, loads) so decode can stall on RAW hazards.
- Sits between decode (reads, reservations) and writeback (one write port per retiring unit).

Parameters:
- NUM_REGS, 32, register count; legal values 16 or 32; address width ADDR_W = $clog2(NUM_REGS).
- DATA_WIDTH, 32, register width in bits.
- NUM_RD_PORTS, 2, read ports; legal range 1..4.
- NUM_WR_PORTS, 2, write ports; legal range 1..3; higher index = higher priority.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- rs_i  in  NUM_RD_PORTS x ADDR_W  read addresses.
- rdata_o  out  NUM_RD_PORTS x DATA_WIDTH  read data, combinational.
- rbusy_o  out  NUM_RD_PORTS  addressed register has a pending write not satisfied this cycle.
- we_i  in  NUM_WR_PORTS  write enables.
- wa_i  in  NUM_WR_PORTS x ADDR_W  write addresses.
- wdata_i  in  NUM_WR_PORTS x DATA_WIDTH  write data.
- rsv_i  in  1  reserve request: mark rsv_addr_i pending.
- rsv_addr_i  in  ADDR_W  register to reserve.
- busy_vec_o  out  NUM_REGS  registered pending bits, bit 0 always 0.

Behaviour:
- Reset: synchronous on clk while reset=1; all registers cleared to 0, all pending bits cleared; writes and reservations in the same cycle are ignored. Outputs during and after reset: rdata_o=0, rbusy_o=0, busy_vec_o=0.
- Register 0: reads always return 0; writes and reservations to address 0 are discarded; never pending.
- Writes: each port p with we_i[p]=1 and wa_i[p]!=0 updates regfile[wa_i[p]] at the next edge.
- Write conflict: several ports writing the same address in one cycle → highest-index port's data is stored. Lower ports are dropped silently.
- Pending bits:
  - Set at the edge when rsv_i=1 and rsv_addr_i!=0.
  - Cleared at the edge when any write port writes that address.
- Simultaneous reserve and write to the same register: the reserve wins. The bit stays set and the data is stored; this models back-to-back producers.
- Reserve of an already pending register: allowed, the bit stays set; no counting.
- Read ports (latency 0, combinational):
  - rdata_o[r] = regfile[rs_i[r]], subject to bypass.
  - rbusy_o[r] = busy[rs_i[r]] AND NOT (a write to rs_i[r] this cycle, when bypass is enabled).
- Address out of range (NUM_REGS=16, address bits above ADDR_W): not representable; ports are sized ADDR_W.
- No handshake on write ports: writeback units own the ordering. The bank accepts every enabled write.

Optional Feature:
- Macro: RS5_REGBANK_BYPASS_EN.
- Defined:
  - A read whose address matches an active write this cycle returns that write's wdata_i, using the highest-priority matching port.
  - rbusy_o is suppressed for that read.
  - Reads of address 0 still return 0.
- Undefined:
  - Reads return stored contents only; new data is visible the cycle after the write edge.
  - rbusy_o reflects the registered pending bit only.
  - Decode stalls one extra cycle per dependency.

Decomposition:
- RS5_pkg gets:
  - localparams REGBANK_MAX_RD_PORTS=4 and REGBANK_MAX_WR_PORTS=3;
  - typedef reg_addr_t (5-bit), used by cores with NUM_REGS=32.
- Sub-module regbank_scoreboard: NUM_REGS pending flops plus set/clear logic.
  - Inputs: reserve, write enables/addresses.
  - Output: busy_vec.
- regbank_mp holds the storage array, write priority mux, read/bypass muxes, and instantiates the scoreboard.

Test Plan:
- Reset: write x5=0xDEADBEEF, assert reset 1 cycle → rs_i[0]=5 reads 0, busy_vec_o=0.
- Zero register: we port0 wa=0 wdata=0xFFFFFFFF, rsv_addr_i=0 → x0 reads 0, busy_vec_o[0]=0.
- Write priority: port0 writes x7=0x11111111 and port1 writes x7=0x22222222 in the same cycle → next cycle x7 reads 0x22222222.
- Scoreboard: rsv x10, then 3 idle cycles → rbusy_o=1 on reads of x10. Port1 writes x10=0xCAFE → bit clears next cycle.
- Same-cycle reserve and write of x12=0x5 → x12 stores 0x5 and busy_vec_o[12]=1 after the edge.
- Bypass (macro defined): x3 pending, port0 writes x3=0xABCD in cycle N → read of x3 in cycle N gives 0xABCD with rbusy_o=0. Macro undefined → old value with rbusy_o=1 in cycle N, 0xABCD in N+1.
- NUM_REGS=16, NUM_RD_PORTS=3 build: write x15=0x1234 → all three ports read 0x1234 when addressed to 15.
